lock_sequencer: RTL

Keypad-driven controller for the combination lock: collects a multi-digit code, checks it against the stored password, and sequences the unlock, password-change and alarm/lockout phases. It replaces single-bit compare handshaking with full digit collection, an attempt counter and timed open/lockout windows. It sits between the debounced keypad front end and the door actuator/alarm outputs.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lock_timer.sv | 28 ++
 rtl/lock_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and defaults for the keypad combination lock sequencer.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_CHECK,
      ST_OPEN,
      ST_NEW,
      ST_LOCKOUT
   } state_t;

   localparam int                DEF_DIGIT_W        = 4;
   localparam int                DEF_NUM_DIGITS     = 4;
   localparam int                DEF_MAX_TRIES      = 3;
   localparam int                DEF_OPEN_CYCLES    = 8;
   localparam int                DEF_LOCKOUT_CYCLES = 16;
   localparam logic [15:0]       DEF_RESET_CODE     = 16'h1234;

   // Width of the tries_left counter; never narrower than one bit.
   function automatic int tries_width(input int max_tries);
      return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lock_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Load on request, otherwise count down and park at zero.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Combination lock controller: digit collection, password check, unlock,
// password change and lockout sequencing with registered outputs.
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int                                DIGIT_W        = DEF_DIGIT_W,
   parameter int                                NUM_DIGITS     = DEF_NUM_DIGITS,
   parameter int                                MAX_TRIES      = DEF_MAX_TRIES,
   parameter int                                OPEN_CYCLES    = DEF_OPEN_CYCLES,
   parameter int                                LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0]     RESET_CODE     = DEF_RESET_CODE
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               digit_valid,
   input  logic [DIGIT_W-1:0]                 digit,
   input  logic                               enter,
   input  logic                               change,
   output logic                               open,
   output logic                               alarm,
   output logic                               new_mode,
   output logic                               pwd_updated,
   output logic [tries_width(MAX_TRIES)-1:0]  tries_left
);

   localparam int CODE_W    = NUM_DIGITS * DIGIT_W;
   localparam int CNT_W     = $clog2(NUM_DIGITS + 1);
   localparam int TRIES_W   = tries_width(MAX_TRIES);
   localparam int TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

   state_t              state;
   logic [CODE_W-1:0]   buffer;
   logic [CODE_W-1:0]   password;
   logic [CNT_W-1:0]    count;
   logic [TRIES_W-1:0]  fail_count;
   logic                op_change;

   logic                count_full;
   logic                code_match;
   logic [TRIES_W-1:0]  fail_next;
   logic [CODE_W-1:0]   buffer_shifted;

   logic                timer_load;
   logic [TIMER_W-1:0]  timer_value;
   logic                timer_done;

   assign count_full     = (count == CNT_W'(NUM_DIGITS));
   assign code_match     = count_full && (buffer == password);
   assign fail_next      = fail_count + TRIES_W'(1);
   assign buffer_shifted = (buffer << DIGIT_W) | CODE_W'(digit);

   // The shared timer is armed during CHECK so it is loaded on the edge that
   // enters OPEN or LOCKOUT; its value is irrelevant for other exits.
   assign timer_load  = (state == ST_CHECK);
   assign timer_value = code_match ? TIMER_W'(OPEN_CYCLES - 1) : TIMER_W'(LOCKOUT_CYCLES - 1);

   lock_timer #(
      .WIDTH      (TIMER_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   // Sequencer state, entry datapath and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         buffer      <= '0;
         count       <= '0;
         // NOTE: the password is a plain register, so it takes its reset code directly.
         password    <= RESET_CODE;
         fail_count  <= '0;
         op_change   <= 1'b0;
         open        <= 1'b0;
         alarm       <= 1'b0;
         new_mode    <= 1'b0;
         pwd_updated <= 1'b0;
         tries_left  <= TRIES_W'(MAX_TRIES);
      end else begin
         pwd_updated <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (digit_valid) begin
                  buffer <= CODE_W'(digit);
                  count  <= CNT_W'(1);
                  state  <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (enter || change) begin
                  op_change <= !enter;
                  state     <= ST_CHECK;
               end else if (digit_valid && !count_full) begin
                  buffer <= buffer_shifted;
                  count  <= count + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               buffer <= '0;
               count  <= '0;
               if (code_match) begin
                  fail_count <= '0;
                  tries_left <= TRIES_W'(MAX_TRIES);
                  if (op_change) begin
                     state    <= ST_NEW;
                     new_mode <= 1'b1;
                  end else begin
                     state <= ST_OPEN;
                     open  <= 1'b1;
                  end
               end else begin
                  fail_count <= fail_next;
                  if (fail_next == TRIES_W'(MAX_TRIES)) begin
                     state      <= ST_LOCKOUT;
                     alarm      <= 1'b1;
                     tries_left <= '0;
                  end else begin
                     state      <= ST_IDLE;
                     tries_left <= TRIES_W'(MAX_TRIES) - fail_next;
                  end
               end
            end
            ST_OPEN: begin
               if (timer_done) begin
                  state <= ST_IDLE;
                  open  <= 1'b0;
               end
            end
            ST_LOCKOUT: begin
               if (timer_done) begin
                  state      <= ST_IDLE;
                  alarm      <= 1'b0;
                  fail_count <= '0;
                  tries_left <= TRIES_W'(MAX_TRIES);
               end
            end
            ST_NEW: begin
               if (enter || change) begin
                  if (enter && count_full) begin
                     password    <= buffer;
                     pwd_updated <= 1'b1;
                  end
                  state    <= ST_IDLE;
                  new_mode <= 1'b0;
                  buffer   <= '0;
                  count    <= '0;
               end else if (digit_valid && !count_full) begin
                  buffer <= buffer_shifted;
                  count  <= count + CNT_W'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               buffer   <= '0;
               count    <= '0;
               open     <= 1'b0;
               alarm    <= 1'b0;
               new_mode <= 1'b0;
            end
         endcase
      end
   end

endmodule
